dsram_arbiter: RTL

DSRAM_ARBITER -- requirements
Module: dsram_arbiter

---
 rtl/dsram_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/dsram_arbiter.sv
// dsram_arbiter: two-requester arbiter in front of a single-port data SRAM.
// The memory stage (M) and a secondary debug/DMA port (D) share the SRAM.
// One grant is issued per access, and only while IDLE. A load walks
// IDLE -> ACCESS -> RESP, and a store walks IDLE -> ACCESS.
// Optional feature macro: DSRAM_ARB_ROUND_ROBIN_EN
//   defined   : a tie goes to the port not granted most recently
//   undefined : a tie always goes to M (fixed priority)
module dsram_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic [3:0]  m_wen,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_ack,
  output logic        m_rvalid,
  output logic [31:0] m_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWNER_M = 1'b0;
  localparam logic OWNER_D = 1'b1;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  wen_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        owner_r;
  logic        grant_valid_s;
  logic        grant_owner_s;

`ifdef DSRAM_ARB_ROUND_ROBIN_EN
  logic        last_grant_r;

  // Remember the most recent winner so the next tie goes to the other port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_r <= OWNER_D;
    end else if (grant_valid_s) begin
      last_grant_r <= grant_owner_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Pick a winner. A grant happens only in IDLE and never while reset is high.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_owner_s = OWNER_M;
    if ((state_r == ST_IDLE) && !reset) begin
      if (m_req && d_req) begin
        grant_valid_s = 1'b1;
`ifdef DSRAM_ARB_ROUND_ROBIN_EN
        grant_owner_s = (last_grant_r == OWNER_D) ? OWNER_M : OWNER_D;
`else
        grant_owner_s = OWNER_M;
`endif
      end else if (m_req) begin
        grant_valid_s = 1'b1;
        grant_owner_s = OWNER_M;
      end else if (d_req) begin
        grant_valid_s = 1'b1;
        grant_owner_s = OWNER_D;
      end else begin
        grant_valid_s = 1'b0;
        grant_owner_s = OWNER_M;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_owner_s = OWNER_M;
    end
  end

  // Next-state logic. After ACCESS, a store returns to IDLE and a load goes to RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_valid_s) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (wen_r != 4'b0000) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_RESP:   state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register. Reset aborts any access that is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the winner's request fields and owner at grant time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen_r   <= 4'b0000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
      owner_r <= OWNER_M;
    end else if (grant_valid_s) begin
      owner_r <= grant_owner_s;
      if (grant_owner_s == OWNER_D) begin
        wen_r   <= d_wen;
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
      end else begin
        wen_r   <= m_wen;
        addr_r  <= m_addr;
        wdata_r <= m_wdata;
      end
    end else begin
      wen_r   <= wen_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      owner_r <= owner_r;
    end
  end

  // Drive the outputs from state. Everything is zero unless its state is active.
  always_comb begin
    m_ack           = grant_valid_s && (grant_owner_s == OWNER_M);
    d_ack           = grant_valid_s && (grant_owner_s == OWNER_D);
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'b0000;
    data_sram_addr  = 32'h0000_0000;
    data_sram_wdata = 32'h0000_0000;
    m_rvalid        = 1'b0;
    m_rdata         = 32'h0000_0000;
    d_rvalid        = 1'b0;
    d_rdata         = 32'h0000_0000;
    busy            = (state_r != ST_IDLE);
    case (state_r)
      ST_ACCESS: begin
        data_sram_en    = 1'b1;
        data_sram_wen   = wen_r;
        data_sram_addr  = addr_r;
        data_sram_wdata = wdata_r;
      end
      ST_RESP: begin
        if (owner_r == OWNER_D) begin
          d_rvalid = 1'b1;
          d_rdata  = data_sram_rdata;
        end else begin
          m_rvalid = 1'b1;
          m_rdata  = data_sram_rdata;
        end
      end
      default: begin
        data_sram_en = 1'b0;
      end
    endcase
  end

endmodule
